// File: rtl/shift_frame_sequencer.sv
// shift_frame_sequencer
//   Sequences an external parallel-load shift chain (NUM_REG stages of WIDTH
//   bits) to turn one parallel frame into a stream of WIDTH-bit beats.
//   A frame arrives on a valid/ready handshake. The chain is loaded, then
//   clocked one stage per accepted output beat. Beats leave top stage first,
//   and the final beat carries sout_last.
//
//   Optional build macro: SHIFT_SEQ_B2B_EN
//     Defined   : a new frame may be accepted on the edge that consumes the
//                 final beat, so frames stream back to back with no gap.
//     Undefined : frames are accepted only from IDLE, which leaves at least
//                 one idle cycle between frames.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low; every output is 0 while low
//   clk_ena    global clock enable; no state changes while low
//   abort      synchronous flush of the current frame; overrides transfers
//   in_valid   frame valid
//   in_ready   frame ready
//   in_frame   parallel frame; stage g holds [(g+1)*WIDTH-1 : g*WIDTH]
//   sr_load    chain parallel-load strobe
//   sr_ena     chain clock enable
//   sr_dfload  chain parallel-load data
//   sr_din     chain serial input (always zero)
//   sr_dout    chain serial output (last stage)
//   sout_valid output beat valid
//   sout_ready output beat ready
//   sout_data  output beat
//   sout_last  final beat of the frame
//   busy       a frame is in flight
//   frame_cnt  number of completed frames, wraps at 16 bits
module shift_frame_sequencer #(
  parameter int WIDTH   = 8,
  parameter int NUM_REG = 3,
  parameter int CNT_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_ena,
  input  logic                     abort,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH*NUM_REG-1:0] in_frame,
  output logic                     sr_load,
  output logic                     sr_ena,
  output logic [WIDTH*NUM_REG-1:0] sr_dfload,
  output logic [WIDTH-1:0]         sr_din,
  input  logic [WIDTH-1:0]         sr_dout,
  output logic                     sout_valid,
  input  logic                     sout_ready,
  output logic [WIDTH-1:0]         sout_data,
  output logic                     sout_last,
  output logic                     busy,
  output logic [15:0]              frame_cnt
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NUM_REG);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef SHIFT_SEQ_B2B_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      fcnt_q, fcnt_d;

  logic in_shift;
  logic last_beat;
  logic ready_c;
  logic frame_acc;
  logic beat_acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;

    // Everything is qualified by rst, so the outputs read 0 during reset
    // without waiting for a clock edge.
    in_shift  = rst && (state_q == SHIFT);
    last_beat = in_shift && (cnt_q == CNT_ONE);
    ready_c   = rst && !abort &&
                ((state_q == IDLE) || (B2B && last_beat && sout_ready));
    frame_acc = in_valid && ready_c && clk_ena;
    beat_acc  = in_shift && sout_ready && clk_ena && !abort;

    if (clk_ena && rst) begin
      if (abort) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        if (beat_acc) begin
          if (last_beat) begin
            fcnt_d  = fcnt_q + 16'd1;
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        // A frame accepted together with the final beat (back-to-back mode)
        // overrides the return to IDLE.
        if (frame_acc) begin
          state_d = SHIFT;
          cnt_d   = CNT_LOAD;
        end
      end
    end
  end

  assign in_ready   = ready_c;
  // The chain gives load priority over shift, so enabling it on a
  // simultaneous load and final beat loads the new frame.
  assign sr_load    = frame_acc;
  assign sr_ena     = frame_acc || beat_acc;
  assign sr_dfload  = rst ? in_frame : '0;
  assign sr_din     = '0;
  assign sout_valid = in_shift;
  assign sout_data  = in_shift ? sr_dout : '0;
  assign sout_last  = last_beat;
  assign busy       = in_shift;
  assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_shift_frame_sequencer.sv
module tb_shift_frame_sequencer;

  localparam int W  = 8;
  localparam int N  = 3;
  localparam int FW = W * N;

`ifdef SHIFT_SEQ_B2B_EN
  localparam bit B2B     = 1'b1;
  localparam int EXP_GAP = 1;
`else
  localparam bit B2B     = 1'b0;
  localparam int EXP_GAP = 2;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          clk_ena;
  logic          abort;
  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] in_frame;
  logic          sr_load;
  logic          sr_ena;
  logic [FW-1:0] sr_dfload;
  logic [W-1:0]  sr_din;
  logic [W-1:0]  sr_dout;
  logic          sout_valid;
  logic          sout_ready;
  logic [W-1:0]  sout_data;
  logic          sout_last;
  logic          busy;
  logic [15:0]   frame_cnt;

  always #5 clk = ~clk;

  shift_frame_sequencer #(
    .WIDTH   (W),
    .NUM_REG (N),
    .CNT_W   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_ena    (clk_ena),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_frame   (in_frame),
    .sr_load    (sr_load),
    .sr_ena     (sr_ena),
    .sr_dfload  (sr_dfload),
    .sr_din     (sr_din),
    .sr_dout    (sr_dout),
    .sout_valid (sout_valid),
    .sout_ready (sout_ready),
    .sout_data  (sout_data),
    .sout_last  (sout_last),
    .busy       (busy),
    .frame_cnt  (frame_cnt)
  );

  // External parallel-load shift chain driven by the DUT (load wins over shift)
  logic [W-1:0] stg [N];
  always @(posedge clk) begin
    if (sr_ena) begin
      if (sr_load) begin
        for (int g = 0; g < N; g++) stg[g] <= sr_dfload[g*W +: W];
      end else begin
        for (int g = N - 1; g > 0; g--) stg[g] <= stg[g-1];
        stg[0] <= sr_din;
      end
    end
  end
  assign sr_dout = stg[N-1];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: remaining beats of the frame in flight, top slice first
  bit           m_busy = 1'b0;
  logic [W-1:0] mq[$];
  logic [15:0]  m_fcnt = '0;
  int           cyc = 0;

  logic [W-1:0] got[$];
  bit           got_last[$];
  int           got_cyc[$];

  always @(negedge clk) begin
    bit           e_rdy, e_load, e_beat;
    logic [W-1:0] e_data;
    cyc++;
    if (!rst) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_sr_load", sr_load, 0);
      chk("rst_sr_ena", sr_ena, 0);
      chk("rst_sr_dfload", sr_dfload, 0);
      chk("rst_sout_valid", sout_valid, 0);
      chk("rst_sout_data", sout_data, 0);
      chk("rst_sout_last", sout_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      m_busy = 1'b0;
      mq.delete();
      m_fcnt = '0;
    end else begin
      e_rdy  = !abort && (!m_busy || (B2B && mq.size() == 1 && sout_ready));
      e_load = in_valid && e_rdy && clk_ena;
      e_beat = m_busy && sout_ready && clk_ena && !abort;
      e_data = m_busy ? mq[0] : '0;
      chk("in_ready", in_ready, e_rdy);
      chk("sr_load", sr_load, e_load);
      chk("sr_ena", sr_ena, e_load || e_beat);
      chk("sr_dfload", sr_dfload, in_frame);
      chk("sr_din", sr_din, 0);
      chk("sout_valid", sout_valid, m_busy);
      chk("sout_data", sout_data, e_data);
      chk("sout_last", sout_last, m_busy && mq.size() == 1);
      chk("busy", busy, m_busy);
      chk("frame_cnt", frame_cnt, m_fcnt);

      if (sout_valid && sout_ready && clk_ena && !abort) begin
        got.push_back(sout_data);
        got_last.push_back(sout_last);
        got_cyc.push_back(cyc);
      end

      if (clk_ena) begin
        if (abort) begin
          m_busy = 1'b0;
          mq.delete();
        end else begin
          if (e_beat) begin
            void'(mq.pop_front());
            if (mq.size() == 0) begin
              m_busy = 1'b0;
              m_fcnt++;
            end
          end
          if (e_load) begin
            for (int g = N - 1; g >= 0; g--) mq.push_back(in_frame[g*W +: W]);
            m_busy = 1'b1;
          end
        end
      end
    end
  end

  // Holds in_valid until the frame is taken; returns at posedge+1 after that edge
  task automatic send_frame(input logic [FW-1:0] f);
    bit done = 1'b0;
    in_frame = f;
    in_valid = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      done = in_ready && clk_ena;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_frame_timeout actual=not_accepted expected=accepted frame=%0h", f);
    end
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout actual=busy expected=idle");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_beats(input string nm, input logic [FW-1:0] f);
    logic [W-1:0] b;
    chk({nm, "_count"}, got.size(), N);
    for (int i = 0; i < N && i < got.size(); i++) begin
      b = f[(N-1-i)*W +: W];
      chk({nm, "_beat"}, got[i], b);
      chk({nm, "_last"}, got_last[i], (i == N - 1));
    end
  endtask

  initial begin
    rst        = 1'b0;
    clk_ena    = 1'b1;
    abort      = 1'b0;
    in_valid   = 1'b0;
    in_frame   = '1;
    sout_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_frame_cnt", frame_cnt, 16'h0000);
    chk("reset_busy", busy, 0);
    rst      = 1'b1;
    in_frame = '0;
    @(posedge clk);
    #1;

    // 1: plain frame, full-rate consumer
    got.delete(); got_last.delete(); got_cyc.delete();
    send_frame(24'h0A0B0C);
    in_valid = 1'b0;
    wait_idle();
    check_beats("t1", 24'h0A0B0C);
    if (got_cyc.size() == 3) chk("t1_consecutive", got_cyc[2] - got_cyc[0], 2);
    chk("t1_frame_cnt", frame_cnt, 16'd1);
    chk("t1_busy", busy, 0);

    // 2: backpressure holds the first beat
    got.delete(); got_last.delete(); got_cyc.delete();
    sout_ready = 1'b0;
    send_frame(24'h0A0B0C);
    in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t2_hold_data", sout_data, 8'h0A);
      chk("t2_hold_sr_ena", sr_ena, 0);
      @(posedge clk);
      #1;
    end
    sout_ready = 1'b1;
    wait_idle();
    check_beats("t2", 24'h0A0B0C);
    chk("t2_frame_cnt", frame_cnt, 16'd2);

    // 3: clock enable low mid-frame
    got.delete(); got_last.delete(); got_cyc.delete();
    send_frame(24'h0A0B0C);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    clk_ena = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("t3_frozen_data", sout_data, 8'h0B);
      @(posedge clk);
      #1;
    end
    clk_ena = 1'b1;
    wait_idle();
    check_beats("t3", 24'h0A0B0C);
    chk("t3_frame_cnt", frame_cnt, 16'd3);

    // 4: abort during the second beat, then a fresh frame
    send_frame(24'h0A0B0C);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    chk("t4_valid_after_abort", sout_valid, 0);
    chk("t4_ready_after_abort", in_ready, 1);
    chk("t4_frame_cnt_kept", frame_cnt, 16'd3);
    @(posedge clk);
    #1;
    got.delete(); got_last.delete(); got_cyc.delete();
    send_frame(24'h112233);
    in_valid = 1'b0;
    wait_idle();
    check_beats("t4", 24'h112233);
    chk("t4_frame_cnt", frame_cnt, 16'd4);

    // 5: two frames pending
    got.delete(); got_last.delete(); got_cyc.delete();
    send_frame(24'h010203);
    send_frame(24'h040506);
    in_valid = 1'b0;
    wait_idle();
    chk("t5_count", got.size(), 6);
    if (got.size() == 6) begin
      chk("t5_beat3", got[2], 8'h03);
      chk("t5_beat4", got[3], 8'h04);
      chk("t5_beat6", got[5], 8'h06);
      chk("t5_gap", got_cyc[3] - got_cyc[2], EXP_GAP);
    end
    chk("t5_frame_cnt", frame_cnt, 16'd6);

    // 6: reset asserted during the second beat
    send_frame(24'h0A0B0C);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("t6_sout_valid", sout_valid, 0);
    chk("t6_sout_data", sout_data, 0);
    chk("t6_busy", busy, 0);
    chk("t6_frame_cnt", frame_cnt, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    got.delete(); got_last.delete(); got_cyc.delete();
    send_frame(24'h0A0B0C);
    in_valid = 1'b0;
    wait_idle();
    check_beats("t6", 24'h0A0B0C);
    chk("t6_frame_cnt_after", frame_cnt, 16'd1);

    // Randomised traffic, checked every cycle against the model
    for (int i = 0; i < 3000; i++) begin
      clk_ena    = ($urandom_range(0, 9) != 0);
      sout_ready = ($urandom_range(0, 3) != 0);
      abort      = ($urandom_range(0, 39) == 0);
      in_valid   = $urandom_range(0, 1) == 1;
      in_frame   = FW'($urandom);
      @(posedge clk);
      #1;
    end
    clk_ena    = 1'b1;
    abort      = 1'b0;
    in_valid   = 1'b0;
    sout_ready = 1'b1;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_frame_sequencer.md
Name: shift_frame_sequencer

Overview:
Controller that sequences an external parallel-load shift chain (NUM_REG stages of WIDTH bits, stage 0 fed by sr_din, last stage on sr_dout) for frame-to-stream conversion. It accepts one parallel frame over a valid/ready handshake and pulses the chain's load. It then clocks the chain one stage per accepted output beat and presents the beats as a valid/ready stream with a last flag. It sits between a frame producer and a word-serial consumer in the datapath.

Parameters:
WIDTH, 8, bits per stage / per output beat
NUM_REG, 3, stages in the controlled chain (beats per frame), >= 1
CNT_W, 4, beat-counter width; NUM_REG < 2**CNT_W is required

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
clk_ena  in  1  global clock enable; no state change when low
abort  in  1  synchronous flush of the current frame
in_valid  in  1  frame valid
in_ready  out  1  frame accepted when in_valid & in_ready & clk_ena
in_frame  in  WIDTH*NUM_REG  parallel frame; stage g gets slice [(g+1)*WIDTH-1 : g*WIDTH]
sr_load  out  1  chain parallel-load strobe
sr_ena  out  1  chain clock enable
sr_dfload  out  WIDTH*NUM_REG  chain load data (= in_frame)
sr_din  out  WIDTH  chain serial input
sr_dout  in  WIDTH  chain serial output (last stage)
sout_valid  out  1  output beat valid
sout_ready  in  1  output beat accepted when sout_valid & sout_ready & clk_ena
sout_data  out  WIDTH  output beat (= sr_dout)
sout_last  out  1  final beat of frame
busy  out  1  state != IDLE
frame_cnt  out  16  completed frames, wraps 0xFFFF -> 0

Behaviour:
- States: IDLE, SHIFT. Counter beat_cnt (CNT_W bits). On rst low, asynchronously: state=IDLE, beat_cnt=0, frame_cnt=0.
- All outputs are 0 while rst is low, including in_ready (combinationally gated by rst).
- IDLE: in_ready=1 (if rst high and abort low), sout_valid=0, busy=0.
- Frame transfer (in_valid & in_ready & clk_ena): sr_load=1 and sr_ena=1 combinationally in the same cycle; sr_dfload=in_frame always. Next state is SHIFT with beat_cnt=NUM_REG.
- The chain must give load priority over shift.
- Latency: frame accepted at edge k -> sout_valid=1 in the cycle after edge k.
- Beat order: first beat is stage NUM_REG-1 (top slice of in_frame), last beat is stage 0.
- SHIFT: sout_valid=1, sout_data=sr_dout, sr_din=0, busy=1, sr_load=0.
  - sr_ena = sout_ready & clk_ena. Each accepted beat advances the chain one stage and decrements beat_cnt.
  - sout_last=1 when beat_cnt==1.
  - Accepted beat with beat_cnt==1: frame_cnt+1, state=IDLE (subject to the optional feature below).
- Backpressure: while sout_ready=0 or clk_ena=0, sr_ena=0 and sout_data/sout_last stay stable.
- clk_ena=0: no handshake completes and no register changes. in_ready/sout_valid keep their state-derived values.
- abort=1 (sampled on an edge with clk_ena=1) has priority over all transfers in that cycle:
  - in_ready=0, sr_load=0, sr_ena=0 combinationally.
  - Next state=IDLE, beat_cnt=0; frame_cnt is unchanged.
  - Chain contents are left stale; the next load overwrites them.
- NUM_REG=1: single-beat frames, sout_last=1 on every beat.
- Reset asserted mid-frame: frame is discarded; after release, IDLE accepts a new frame normally.

Optional Feature:
Macro SHIFT_SEQ_B2B_EN.
- Defined: in SHIFT with beat_cnt==1 and sout_ready=1, in_ready=1. A frame transfer on that same edge asserts sr_load=1, sr_ena=1, increments frame_cnt, and stays in SHIFT with beat_cnt=NUM_REG. Result is zero-bubble streaming.
- Undefined: in_ready=1 only in IDLE, giving at least one idle cycle between frames.

Test Plan:
1. WIDTH=8, NUM_REG=3. Release rst, send in_frame=0x0A0B0C with sout_ready=1 -> sout_data 0x0A,0x0B,0x0C on 3 consecutive cycles, sout_last only with 0x0C, frame_cnt=1, busy drops after.
2. Same frame, sout_ready=0 for 3 cycles after first beat -> sout_data holds 0x0A, sr_ena=0 throughout, then 0x0B,0x0C follow; frame_cnt=1.
3. clk_ena=0 for 2 cycles mid-frame with sout_ready=1 -> no beat consumed, beat_cnt frozen, stream resumes with correct next value.
4. abort during beat 0x0B -> next cycle sout_valid=0, in_ready=1, frame_cnt unchanged; new frame 0x112233 streams 0x11,0x22,0x33.
5. Frames 0x010203 and 0x040506 both pending -> with SHIFT_SEQ_B2B_EN: 6 consecutive beats with no gap; without: exactly one cycle of sout_valid=0 between 0x03 and 0x04; frame_cnt=2.
6. rst low during beat 0x0B -> all outputs 0 immediately, frame_cnt=0; after release, frame 0x0A0B0C streams normally.
